// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD_CTRL command sequencer.
//   cmd_t   : 3-bit LCD_CTRL command code
//   state_t : sequencer FSM states
//   sat_inc : saturating increment for the 8-bit issue counter
package lcd_pkg;

    localparam int unsigned CMD_W   = 3;
    localparam int unsigned COUNT_W = 8;

    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_WRITE    = 3'd0;
    localparam cmd_t CMD_UP       = 3'd1;
    localparam cmd_t CMD_DOWN     = 3'd2;
    localparam cmd_t CMD_LEFT     = 3'd3;
    localparam cmd_t CMD_RIGHT    = 3'd4;
    localparam cmd_t CMD_AVERAGE  = 3'd5;
    localparam cmd_t CMD_MIRROR_X = 3'd6;
    localparam cmd_t CMD_MIRROR_Y = 3'd7;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        ISSUE,
        GUARD,
        WAIT_BUSY,
        WAIT_DONE,
        FINISHED
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO: synchronous push/pop, flush clears contents and wins over push.
//   clk, reset    : clock, async active-low reset
//   push, din     : write request and data (ignored when full or flushing)
//   pop           : read request (ignored when empty or flushing)
//   flush         : drop all entries
//   head_c        : current head entry (combinational)
//   empty_c       : FIFO empty (combinational from level)
//   level         : registered occupancy
//   level_next_c  : occupancy after this edge (lets the parent register host_ready)
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  cmd_t          din,
    input  logic          pop,
    input  logic          flush,
    output cmd_t          head_c,
    output logic          empty_c,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_next_c
);

    localparam int unsigned AW = LW - 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty_c = (level == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty_c & ~flush;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        level_next_c = level + LW'(push_ok) - LW'(pop_ok);
        if (flush) begin
            level_next_c = '0;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_next_c;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage (no reset needed; only read when occupied)
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Host-side command scheduler for LCD_CTRL: queues host commands, issues them
// one at a time with the cmd/cmd_valid/busy handshake and tracks the write.
//   clk, reset              : clock, async active-low reset
//   host_cmd/valid/ready    : host command intake (transfer on valid & ready)
//   flush                   : drop all queued, not-yet-issued commands
//   cmd, cmd_valid          : issue to LCD_CTRL (cmd_valid is a 1-cycle strobe)
//   busy, done              : LCD_CTRL status
//   cmd_count               : issued commands, saturating at 255
//   frame_done              : 1-cycle pulse when the write completes
//   wd_err                  : sticky watchdog error
//   fifo_level              : FIFO occupancy
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 8,
    parameter  int unsigned BOOT_GUARD = 2,
    parameter  int unsigned WD_LIMIT   = 1023,
    localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    host_cmd,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          flush,
    output logic [2:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          done,
    output logic [7:0]    cmd_count,
    output logic          frame_done,
    output logic          wd_err,
    output logic [LW-1:0] fifo_level
);

    localparam int unsigned BW = $clog2(BOOT_GUARD + 2);
    localparam int unsigned WW = $clog2(WD_LIMIT + 1);

    state_t        state, state_n;
    logic [BW-1:0] boot_cnt, boot_cnt_n;
    logic [WW-1:0] wd_cnt, wd_cnt_n;
    cmd_t          cmd_n;
    logic          cmd_valid_n;
    logic [7:0]    cmd_count_n;
    logic          frame_done_n;
    logic          wd_err_n;
    logic          host_ready_n;

    logic          push;
    logic          pop;
    logic          issue;
    cmd_t          head;
    logic          empty;
    logic [LW-1:0] level_next;

    assign push = host_valid & host_ready;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .din          (host_cmd),
        .pop          (pop),
        .flush        (flush),
        .head_c       (head),
        .empty_c      (empty),
        .level        (fifo_level),
        .level_next_c (level_next)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            boot_cnt   <= '0;
            wd_cnt     <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            cmd_count  <= '0;
            frame_done <= 1'b0;
            wd_err     <= 1'b0;
            host_ready <= 1'b0;
        end else begin
            state      <= state_n;
            boot_cnt   <= boot_cnt_n;
            wd_cnt     <= wd_cnt_n;
            cmd        <= cmd_n;
            cmd_valid  <= cmd_valid_n;
            cmd_count  <= cmd_count_n;
            frame_done <= frame_done_n;
            wd_err     <= wd_err_n;
            host_ready <= host_ready_n;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n      = state;
        boot_cnt_n   = boot_cnt;
        wd_cnt_n     = wd_cnt;
        cmd_n        = cmd;
        cmd_valid_n  = 1'b0;
        cmd_count_n  = cmd_count;
        frame_done_n = 1'b0;
        wd_err_n     = wd_err;
        pop          = 1'b0;
        issue        = 1'b0;

        case (state)
            BOOT: begin
                if (boot_cnt < BW'(BOOT_GUARD)) begin
                    boot_cnt_n = boot_cnt + BW'(1);
                end else if (!busy) begin
                    // Boot exit acts as the first IDLE decision, keeping the
                    // one-cycle queue-to-issue latency for the first command.
                    state_n = IDLE;
                    issue   = !empty && !flush;
                end
            end
            IDLE: begin
                issue = !empty && !busy && !flush;
            end
            ISSUE: begin
                state_n = GUARD;
            end
            GUARD: begin
                wd_cnt_n = '0;
                state_n  = (cmd == CMD_WRITE) ? WAIT_DONE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!busy) begin
                    state_n = IDLE;
                end else if (wd_cnt == WW'(WD_LIMIT - 1)) begin
                    wd_err_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    wd_cnt_n = wd_cnt + WW'(1);
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    frame_done_n = 1'b1;
                    state_n      = FINISHED;
                end else if (wd_cnt == WW'(WD_LIMIT - 1)) begin
                    wd_err_n = 1'b1;
                    state_n  = FINISHED;
                end else begin
                    wd_cnt_n = wd_cnt + WW'(1);
                end
            end
            FINISHED: begin
                state_n = FINISHED;
            end
            default: begin
                state_n = BOOT;
            end
        endcase

        if (issue) begin
            pop         = 1'b1;
            state_n     = ISSUE;
            cmd_n       = head;
            cmd_valid_n = 1'b1;
            cmd_count_n = sat_inc(cmd_count);
        end

        // Registered from next-cycle occupancy so it never lags a push
        host_ready_n = (level_next != LW'(FIFO_DEPTH)) && (state_n != FINISHED);
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: a scoreboard queue of expected
// issue order, a simple LCD_CTRL busy/done model, a per-cycle vector table for
// the FIFO-full scenario and hand-written sequences for the other corners.
module tb_lcd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] host_cmd = 3'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       flush = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic [7:0] cmd_count;
    logic       frame_done;
    logic       wd_err;
    logic [3:0] fifo_level;

    logic busy_force = 1'b0;
    logic busy_model = 1'b0;
    logic done_model = 1'b0;
    bit   model_en   = 1'b0;

    assign busy = busy_force | busy_model;
    assign done = done_model;

    int n_chk  = 0;
    int n_fail = 0;
    int cv_cnt = 0;
    int fd_cnt = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic       valid;
        logic [2:0] cmd;
        logic       busy;
        logic       exp_ready;
        logic [3:0] exp_level;
        logic       exp_cv;
    } vec_t;

    vec_t tbl[13];

    lcd_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .flush      (flush),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .cmd_count  (cmd_count),
        .frame_done (frame_done),
        .wd_err     (wd_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Issue monitor: every strobe must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            cv_cnt = 0;
            fd_cnt = 0;
        end else begin
            if (cmd_valid) begin
                cv_cnt++;
                chk("sb_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("cmd_order", int'(cmd), int'(exp_q.pop_front()));
            end
            if (frame_done) fd_cnt++;
        end
    end

    // LCD_CTRL model: busy 3 cycles per command, 64 for a write then a done pulse
    initial begin
        int  rem;
        bit  is_wr;
        rem = 0;
        is_wr = 1'b0;
        forever begin
            @(negedge clk);
            done_model = 1'b0;
            if (!reset) begin
                busy_model = 1'b0;
            end else if (model_en && cmd_valid) begin
                busy_model = 1'b1;
                is_wr = (cmd == 3'd0);
                rem = is_wr ? 64 : 3;
            end else if (busy_model) begin
                rem--;
                if (rem == 0) begin
                    busy_model = 1'b0;
                    if (is_wr) done_model = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        host_valid = 1'b0;
        flush = 1'b0;
        model_en = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic [2:0] c);
        host_valid = 1'b1;
        host_cmd = c;
        exp_q.push_back(c);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_cv(input int target, input int limit, input string nm);
        int k = 0;
        while (cv_cnt < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(cv_cnt >= target), 1);
    endtask

    initial begin
        logic [2:0] fill_cmd[8];
        logic       prev_ready;
        bit         early;
        int         k;

        fill_cmd = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, fill_cmd[i], 1'b1, (i != 7), 4'(i + 1), 1'b0};
        tbl[8]  = '{1'b1, 3'd2, 1'b1, 1'b0, 4'd8, 1'b0};
        tbl[9]  = '{1'b1, 3'd2, 1'b0, 1'b1, 4'd7, 1'b1};
        tbl[10] = '{1'b1, 3'd2, 1'b0, 1'b0, 4'd8, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_host_ready", int'(host_ready), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_count", int'(cmd_count), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_wd_err", int'(wd_err), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);

        // Boot: busy high 70 cycles after release, cmd 3 queued
        busy_force = 1'b1;
        do_reset();
        push_cmd(3'd3);
        early = 1'b0;
        for (int i = 2; i <= 70; i++) begin
            if (cmd_valid) early = 1'b1;
            if (i != 70) @(negedge clk);
        end
        chk("boot_no_early_issue", int'(early), 0);
        busy_force = 1'b0;
        @(negedge clk);
        chk("boot_issue_latency", int'(cmd_valid), 1);
        chk("boot_issue_cmd", int'(cmd), 3);
        repeat (5) @(negedge clk);

        // FIFO full: per-cycle vectors while BOOT is held by busy
        busy_force = 1'b1;
        do_reset();
        prev_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            busy_force = tbl[i].busy;
            host_valid = tbl[i].valid;
            host_cmd = tbl[i].cmd;
            if (tbl[i].valid && prev_ready) exp_q.push_back(tbl[i].cmd);
            @(negedge clk);
            chk($sformatf("full_level_%0d", i), int'(fifo_level), int'(tbl[i].exp_level));
            chk($sformatf("full_ready_%0d", i), int'(host_ready), int'(tbl[i].exp_ready));
            chk($sformatf("full_cv_%0d", i), int'(cmd_valid), int'(tbl[i].exp_cv));
            prev_ready = tbl[i].exp_ready;
        end
        host_valid = 1'b0;
        busy_force = 1'b0;
        model_en = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("full_drained", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        chk("full_level_end", int'(fifo_level), 0);
        chk("full_cmd_count", int'(cmd_count), 9);

        // Sequence with write: 1,4,5,6,0
        do_reset();
        model_en = 1'b1;
        push_cmd(3'd1);
        push_cmd(3'd4);
        push_cmd(3'd5);
        push_cmd(3'd6);
        push_cmd(3'd0);
        k = 0;
        while (fd_cnt == 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        chk("seq_frame_done_count", fd_cnt, 1);
        chk("seq_issue_count", cv_cnt, 5);
        chk("seq_cmd_count", int'(cmd_count), 5);
        chk("seq_host_ready", int'(host_ready), 0);
        chk("seq_sb_empty", exp_q.size(), 0);
        chk("seq_wd_err", int'(wd_err), 0);

        // Flush with one command in flight and five queued
        busy_force = 1'b1;
        do_reset();
        for (int i = 1; i <= 6; i++) push_cmd(3'(i));
        model_en = 1'b1;
        busy_force = 1'b0;
        wait_cv(1, 20, "flush_first_issue");
        chk("flush_queued", int'(fifo_level), 5);
        flush = 1'b1;
        host_valid = 1'b1;
        host_cmd = 3'd7;
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        host_valid = 1'b0;
        chk("flush_level", int'(fifo_level), 0);
        repeat (30) @(negedge clk);
        chk("flush_no_more_issue", cv_cnt, 1);
        chk("flush_cmd_count", int'(cmd_count), 1);
        chk("flush_level_end", int'(fifo_level), 0);
        push_cmd(3'd5);
        wait_cv(2, 20, "flush_resume_issue");

        // Watchdog on a write that never completes
        do_reset();
        push_cmd(3'd0);
        k = 0;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wd_issue_seen", int'(cmd_valid), 1);
        repeat (1024) @(negedge clk);
        chk("wd_err_not_early", int'(wd_err), 0);
        @(negedge clk);
        chk("wd_err_set", int'(wd_err), 1);
        chk("wd_frame_done", fd_cnt, 0);
        chk("wd_finished_ready", int'(host_ready), 0);
        host_valid = 1'b1;
        host_cmd = 3'd2;
        @(negedge clk);
        host_valid = 1'b0;
        chk("wd_finished_no_push", int'(fifo_level), 0);

        // Reset asserted while in WAIT_BUSY
        busy_force = 1'b1;
        do_reset();
        push_cmd(3'd2);
        push_cmd(3'd3);
        push_cmd(3'd4);
        busy_force = 1'b0;
        k = 0;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        busy_force = 1'b1;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_host_ready", int'(host_ready), 0);
        chk("arst_cmd", int'(cmd), 0);
        chk("arst_cmd_count", int'(cmd_count), 0);
        chk("arst_fifo_level", int'(fifo_level), 0);
        chk("arst_wd_err", int'(wd_err), 0);
        exp_q.delete();
        @(negedge clk);
        busy_force = 1'b0;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst_no_replay", cv_cnt, 0);
        chk("arst_level_after", int'(fifo_level), 0);
        chk("arst_count_after", int'(cmd_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
